// File: rtl/jlsemi_util_clksw_pkg.sv
// Shared types and constants for the clock-switch sequencer.
package jlsemi_util_clksw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATE   = 2'd1,
    ST_SETTLE = 2'd2
  } clksw_state_e;

  localparam int unsigned SW_CNT_W   = 8;
  localparam int unsigned MIN_CYCLES = 1;

  // A window length is usable when it is at least one cycle and its
  // reload value (cycles-1) fits in the counter.
  function automatic bit cycles_ok(input int unsigned cycles, input int unsigned cnt_w);
    return (cycles >= MIN_CYCLES) && (64'(cycles) <= (64'd1 << cnt_w));
  endfunction

endpackage

// File: rtl/jlsemi_util_clksw_dncnt.sv
// Loadable down-counter with zero flag; reused for the gate and settle windows.
module jlsemi_util_clksw_dncnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/jlsemi_util_clksw_ctrl.sv
// Clock-switch sequencer: gate, quiet window, flip mux select, settle, ungate.
module jlsemi_util_clksw_ctrl
  import jlsemi_util_clksw_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter logic        RESET_SEL     = 1'b0,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_vld_i,
  input  logic                req_sel_i,
  output logic                req_rdy_o,
  input  logic                dft_test_clk_en_i,
  output logic                sel_o,
  output logic                clk_gate_en_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [SW_CNT_W-1:0] sw_cnt_o
);

  if (!cycles_ok(GATE_CYCLES, CNT_W)) begin : g_bad_gate_cycles
    $error("GATE_CYCLES must be >= 1 and fit in CNT_W bits");
  end
  if (!cycles_ok(SETTLE_CYCLES, CNT_W)) begin : g_bad_settle_cycles
    $error("SETTLE_CYCLES must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  clksw_state_e        state_q, state_d;
  logic                sel_q, sel_d;
  logic                tgt_q, tgt_d;
  logic                gate_en_q, gate_en_d;
  logic                done_q, done_d;
  logic                noop_pend_q, noop_pend_d;
  logic [SW_CNT_W-1:0] sw_cnt_q, sw_cnt_d;

  logic             accept;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  jlsemi_util_clksw_dncnt #(
    .CNT_W (CNT_W)
  ) u_dncnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign req_rdy_o = (state_q == ST_IDLE) & ~dft_test_clk_en_i & ~rst_i;
  assign accept    = req_vld_i & req_rdy_o;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    tgt_d        = tgt_q;
    gate_en_d    = gate_en_q;
    sw_cnt_d     = sw_cnt_q;
    noop_pend_d  = 1'b0;
    // A no-op accept is acknowledged one edge later than a real completion.
    done_d       = noop_pend_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_sel_i != sel_q) begin
            tgt_d        = req_sel_i;
            gate_en_d    = 1'b0;
            cnt_load     = 1'b1;
            cnt_load_val = GATE_LOAD;
            state_d      = ST_GATE;
          end else begin
            noop_pend_d  = 1'b1;
          end
        end
      end
      ST_GATE: begin
        if (cnt_zero) begin
          sel_d        = tgt_q;
          cnt_load     = 1'b1;
          cnt_load_val = SETTLE_LOAD;
          state_d      = ST_SETTLE;
        end else begin
          cnt_dec      = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          gate_en_d = 1'b1;
          done_d    = 1'b1;
          sw_cnt_d  = sw_cnt_q + 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_dec   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      sel_q       <= RESET_SEL;
      tgt_q       <= RESET_SEL;
      gate_en_q   <= 1'b1;
      done_q      <= 1'b0;
      noop_pend_q <= 1'b0;
      sw_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      tgt_q       <= tgt_d;
      gate_en_q   <= gate_en_d;
      done_q      <= done_d;
      noop_pend_q <= noop_pend_d;
      sw_cnt_q    <= sw_cnt_d;
    end
  end

  assign sel_o         = sel_q;
  assign clk_gate_en_o = gate_en_q | dft_test_clk_en_i;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;
  assign sw_cnt_o      = sw_cnt_q;

endmodule

// File: tb/tb_jlsemi_util_clksw_ctrl.sv
// Directed bench for the clock-switch sequencer with default parameters.
module tb_jlsemi_util_clksw_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_vld_i;
  logic       req_sel_i;
  logic       req_rdy_o;
  logic       dft_test_clk_en_i;
  logic       sel_o;
  logic       clk_gate_en_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] sw_cnt_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        exp_sel;

  jlsemi_util_clksw_ctrl #(
    .GATE_CYCLES   (4),
    .SETTLE_CYCLES (8),
    .RESET_SEL     (1'b0),
    .CNT_W         (8)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .req_vld_i         (req_vld_i),
    .req_sel_i         (req_sel_i),
    .req_rdy_o         (req_rdy_o),
    .dft_test_clk_en_i (dft_test_clk_en_i),
    .sel_o             (sel_o),
    .clk_gate_en_o     (clk_gate_en_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .sw_cnt_o          (sw_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i             = 1'b1;
    req_vld_i         = 1'b0;
    req_sel_i         = 1'b0;
    dft_test_clk_en_i = 1'b0;
    step(2);

    // Reset state
    chk("rst_rdy",  32'(req_rdy_o),     32'd0);
    chk("rst_sel",  32'(sel_o),         32'd0);
    chk("rst_gate", 32'(clk_gate_en_o), 32'd1);
    chk("rst_busy", 32'(busy_o),        32'd0);
    chk("rst_done", 32'(done_o),        32'd0);
    chk("rst_cnt",  32'(sw_cnt_o),      32'd0);
    rst_i = 1'b0;
    #1;
    chk("idle_rdy", 32'(req_rdy_o), 32'd1);

    // Real switch 0 -> 1
    req_vld_i = 1'b1;
    req_sel_i = 1'b1;
    step(1);                                   // E0
    req_vld_i = 1'b0;
    chk("sw1_gate_e0", 32'(clk_gate_en_o), 32'd0);
    chk("sw1_busy_e0", 32'(busy_o),        32'd1);
    chk("sw1_rdy_e0",  32'(req_rdy_o),     32'd0);
    chk("sw1_sel_e0",  32'(sel_o),         32'd0);
    step(3);                                   // E0+3
    chk("sw1_sel_e3",  32'(sel_o),         32'd0);
    chk("sw1_gate_e3", 32'(clk_gate_en_o), 32'd0);
    step(1);                                   // E0+4
    chk("sw1_sel_e4",  32'(sel_o),         32'd1);
    chk("sw1_gate_e4", 32'(clk_gate_en_o), 32'd0);
    step(7);                                   // E0+11
    chk("sw1_gate_e11", 32'(clk_gate_en_o), 32'd0);
    chk("sw1_done_e11", 32'(done_o),        32'd0);
    step(1);                                   // E0+12
    chk("sw1_gate_e12", 32'(clk_gate_en_o), 32'd1);
    chk("sw1_done_e12", 32'(done_o),        32'd1);
    chk("sw1_rdy_e12",  32'(req_rdy_o),     32'd1);
    chk("sw1_busy_e12", 32'(busy_o),        32'd0);
    chk("sw1_cnt_e12",  32'(sw_cnt_o),      32'd1);
    step(1);
    chk("sw1_done_end", 32'(done_o),        32'd0);

    // No-op request (sel already 1)
    req_vld_i = 1'b1;
    req_sel_i = 1'b1;
    step(1);                                   // E0
    req_vld_i = 1'b0;
    chk("noop_done_e0", 32'(done_o),        32'd0);
    chk("noop_gate_e0", 32'(clk_gate_en_o), 32'd1);
    chk("noop_rdy_e0",  32'(req_rdy_o),     32'd1);
    chk("noop_busy_e0", 32'(busy_o),        32'd0);
    step(1);                                   // E0+1
    chk("noop_done_e1", 32'(done_o),        32'd1);
    chk("noop_gate_e1", 32'(clk_gate_en_o), 32'd1);
    chk("noop_cnt_e1",  32'(sw_cnt_o),      32'd1);
    chk("noop_sel_e1",  32'(sel_o),         32'd1);
    step(1);
    chk("noop_done_e2", 32'(done_o),        32'd0);

    // Reset pulse during GATE
    req_vld_i = 1'b1;
    req_sel_i = 1'b0;
    step(1);                                   // E0
    req_vld_i = 1'b0;
    step(2);
    chk("abort_busy_pre", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    step(1);
    chk("abort_sel",  32'(sel_o),         32'd0);
    chk("abort_gate", 32'(clk_gate_en_o), 32'd1);
    chk("abort_busy", 32'(busy_o),        32'd0);
    chk("abort_done", 32'(done_o),        32'd0);
    chk("abort_cnt",  32'(sw_cnt_o),      32'd0);
    rst_i = 1'b0;
    for (int unsigned i = 0; i < 14; i++) begin
      step(1);
      chk("abort_no_done", 32'(done_o), 32'd0);
    end

    // Back-to-back 1 then 0 with vld held
    req_vld_i = 1'b1;
    req_sel_i = 1'b1;
    step(1);                                   // E0
    req_sel_i = 1'b0;
    step(11);                                  // E0+11
    chk("b2b_rdy_busy", 32'(req_rdy_o), 32'd0);
    step(1);                                   // E0+12
    chk("b2b_done1", 32'(done_o),    32'd1);
    chk("b2b_rdy1",  32'(req_rdy_o), 32'd1);
    chk("b2b_sel1",  32'(sel_o),     32'd1);
    step(1);                                   // E0+13, second accept
    req_vld_i = 1'b0;
    chk("b2b_busy2", 32'(busy_o),        32'd1);
    chk("b2b_gate2", 32'(clk_gate_en_o), 32'd0);
    step(3);
    chk("b2b_sel_pre", 32'(sel_o), 32'd1);
    step(1);                                   // E0+17
    chk("b2b_sel0", 32'(sel_o), 32'd0);
    step(8);                                   // E0+25
    chk("b2b_done2", 32'(done_o),   32'd1);
    chk("b2b_cnt2",  32'(sw_cnt_o), 32'd2);
    step(1);

    // DFT mode asserted during SETTLE
    req_vld_i = 1'b1;
    req_sel_i = 1'b1;
    step(1);                                   // E0
    req_vld_i = 1'b0;
    step(4);                                   // E0+4, SETTLE
    chk("dft_gate_pre", 32'(clk_gate_en_o), 32'd0);
    dft_test_clk_en_i = 1'b1;
    #1;
    chk("dft_gate_force", 32'(clk_gate_en_o), 32'd1);
    step(7);                                   // E0+11
    chk("dft_done_e11", 32'(done_o), 32'd0);
    step(1);                                   // E0+12
    chk("dft_done_e12", 32'(done_o),        32'd1);
    chk("dft_cnt",      32'(sw_cnt_o),      32'd3);
    chk("dft_rdy_low",  32'(req_rdy_o),     32'd0);
    chk("dft_busy",     32'(busy_o),        32'd0);
    req_vld_i = 1'b1;
    req_sel_i = 1'b0;
    step(3);
    chk("dft_no_accept", 32'(busy_o), 32'd0);
    chk("dft_sel_hold",  32'(sel_o),  32'd1);
    req_vld_i = 1'b0;
    dft_test_clk_en_i = 1'b0;
    #1;
    chk("dft_rdy_back", 32'(req_rdy_o),     32'd1);
    chk("dft_gate_back", 32'(clk_gate_en_o), 32'd1);

    // Counter wrap: 253 more switches bring the count from 3 through 255 to 0
    exp_sel = 1'b1;
    for (int unsigned n = 0; n < 253; n++) begin
      req_vld_i = 1'b1;
      req_sel_i = ~exp_sel;
      exp_sel   = ~exp_sel;
      step(1);
      req_vld_i = 1'b0;
      step(12);
      if (n == 251) chk("wrap_cnt255", 32'(sw_cnt_o), 32'd255);
    end
    chk("wrap_cnt0", 32'(sw_cnt_o), 32'd0);
    chk("wrap_sel",  32'(sel_o),    32'(exp_sel));
    chk("wrap_done", 32'(done_o),   32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
